td4_fetch_decode: RTL and testbench

Fetch/decode stage directly upstream of the TD4 operation (execute) functions. Holds a 16x8 program memory with a load port, fetches the instruction at the current ip, and splits it into a 4-bit opcode and a 4-bit immediate. It presents each instruction to execute over a valid/ready handshake. A run/single-step controller sequences it.

---
 rtl/td4_fetch_decode.sv | 144 ++++++++++++++
 tb/tb_td4_fetch_decode.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/td4_fetch_decode.sv
// td4_fetch_decode: fetch/decode stage ahead of the TD4 execute functions.
// Holds a 16x8 program memory with a load port. It fetches mem[ip] into a
// holding register and presents opcode/immediate over a valid/ready handshake.
// A run/single-step controller sequences the stage.
// Optional feature: define TD4_HALT_DETECT_EN to stop on a JMP-to-self
// (op=1111, imm==ip). The stage then parks in HALTED until run drops.
module td4_fetch_decode #(
  parameter int PROG_DEPTH = 16,
  parameter int INSTR_W    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               prog_valid,
  output logic               prog_ready,
  input  logic [3:0]         prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic               run,
  input  logic               step_req,
  input  logic [3:0]         ip,
  output logic               issue_valid,
  input  logic               issue_ready,
  output logic [3:0]         op,
  output logic [3:0]         imm,
  output logic               op_legal,
  output logic               halted
);

  // Opcodes the execute stage implements. Bit n set means opcode n is legal.
  // Illegal opcodes are 1000, 1010, 1100 and 1101.
  localparam logic [15:0] LEGAL_OPS = 16'b1100_1010_1111_1111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ISSUE
`ifdef TD4_HALT_DETECT_EN
    , ST_HALTED
`endif
  } state_t;

  state_t               state_reg;
  state_t               state_next;
  logic [INSTR_W-1:0]   instr_reg;
  logic [INSTR_W-1:0]   mem [PROG_DEPTH];
  logic                 mem_we;
  logic [15:0]          op_hit;

  // Loads are only accepted while idle. Reset also suppresses a write, so a
  // stray prog_valid during reset cannot corrupt the program.
  assign mem_we = rst_n && (state_reg == ST_IDLE) && prog_valid;

  // Program memory write port. The memory is deliberately not reset, so a
  // loaded program survives a reset of the controller.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[prog_addr] <= prog_data;
    end
  end

  // Registered read. The instruction at ip is captured while in FETCH and
  // then held unchanged for the whole ISSUE phase, whatever ip does.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_reg <= '0;
    end else if (state_reg == ST_FETCH) begin
      instr_reg <= mem[ip];
    end
  end

  // Controller state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  assign op  = instr_reg[7:4];
  assign imm = instr_reg[3:0];

  // One-hot compare against each legal opcode. Exactly one hit can be set.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_legal
      assign op_hit[gi] = LEGAL_OPS[gi] && (op == 4'(gi));
    end
  endgenerate

  assign op_legal = |op_hit;

  // Next-state and handshake/status outputs.
  always_comb begin
    state_next  = state_reg;
    issue_valid = 1'b0;
    prog_ready  = 1'b0;
    halted      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        prog_ready = 1'b1;
        // A load in the same cycle wins over run or step.
        if (!prog_valid && (run || step_req)) begin
          state_next = ST_FETCH;
        end
      end
      ST_FETCH: begin
        state_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        issue_valid = 1'b1;
        if (issue_ready) begin
`ifdef TD4_HALT_DETECT_EN
          if ((op == 4'b1111) && (imm == ip)) begin
            state_next = ST_HALTED;
          end else if (run) begin
            state_next = ST_FETCH;
          end else begin
            state_next = ST_IDLE;
          end
`else
          if (run) begin
            state_next = ST_FETCH;
          end else begin
            state_next = ST_IDLE;
          end
`endif
        end
      end
`ifdef TD4_HALT_DETECT_EN
      ST_HALTED: begin
        halted = 1'b1;
        // Only dropping run releases the halt. step_req is ignored here.
        if (!run) begin
          state_next = ST_IDLE;
        end
      end
`endif
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_td4_fetch_decode.sv
// tb_td4_fetch_decode: directed plus randomized checks of td4_fetch_decode
// against a program-memory model and an instruction-pointer model.
// Honours TD4_HALT_DETECT_EN for the halt scenario.
module tb_td4_fetch_decode;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       prog_valid;
  logic       prog_ready;
  logic [3:0] prog_addr;
  logic [7:0] prog_data;
  logic       run;
  logic       step_req;
  logic [3:0] ip;
  logic       issue_valid;
  logic       issue_ready;
  logic [3:0] op;
  logic [3:0] imm;
  logic       op_legal;
  logic       halted;

  int errors = 0;
  int checks = 0;

  logic [7:0] mmem [16];
  logic [3:0] ipm;

  always #5 clk = ~clk;

  td4_fetch_decode dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .prog_valid  (prog_valid),
    .prog_ready  (prog_ready),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .run         (run),
    .step_req    (step_req),
    .ip          (ip),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .op          (op),
    .imm         (imm),
    .op_legal    (op_legal),
    .halted      (halted)
  );

  // The twelve TD4 opcodes.
  function automatic logic legal_ref(input logic [3:0] o);
    case (o)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7,
      4'h9, 4'hB, 4'hE, 4'hF: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check op/imm/op_legal against the model instruction at address a.
  task automatic expect_instr(input string tag, input logic [3:0] a);
    logic [7:0] w;
    w = mmem[a];
    check({tag, "_valid"}, issue_valid, 1'b1);
    check({tag, "_op"}, op, w[7:4]);
    check({tag, "_imm"}, imm, w[3:0]);
    check({tag, "_legal"}, op_legal, legal_ref(w[7:4]));
    $display("issue %s: addr=%0h op=%0h imm=%0h legal=%0b", tag, a, op, imm, op_legal);
  endtask

  // Called at a negedge while the DUT is idle.
  task automatic load_word(input logic [3:0] a, input logic [7:0] d);
    prog_valid = 1'b1;
    prog_addr  = a;
    prog_data  = d;
    check("load_ready", prog_ready, 1'b1);
    @(negedge clk);
    prog_valid = 1'b0;
    mmem[a]    = d;
    $display("load mem[%0h]=%02h", a, d);
  endtask

  // Single-step from IDLE. Leaves the DUT in ISSUE with issue_ready low.
  task automatic do_step(input string tag, input logic [3:0] a);
    ip       = a;
    step_req = 1'b1;
    @(negedge clk);
    step_req = 1'b0;
    check({tag, "_fetch_novalid"}, issue_valid, 1'b0);
    @(negedge clk);
    expect_instr(tag, a);
  endtask

  // Complete the handshake and expect a return to IDLE (run is low).
  task automatic handshake_to_idle(input string tag);
    issue_ready = 1'b1;
    @(negedge clk);
    issue_ready = 1'b0;
    check({tag, "_post_hs_valid"}, issue_valid, 1'b0);
    check({tag, "_post_hs_idle"}, prog_ready, 1'b1);
  endtask

  initial begin
    logic [7:0] d;
    logic [3:0] av;
    int         cyc;
    int         hs;
    logic       rdy;

    rst_n = 1'b0; prog_valid = 1'b0; prog_addr = '0; prog_data = '0;
    run = 1'b0; step_req = 1'b0; ip = '0; issue_ready = 1'b0; ipm = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_valid", issue_valid, 1'b0);
    check("rst_op", op, 4'h0);
    check("rst_imm", imm, 4'h0);
    check("rst_legal", op_legal, 1'b1);
    check("rst_halted", halted, 1'b0);
    check("rst_prog_ready", prog_ready, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);

    // Random program with fixed words at 0, 1 and 6. No JMP-to-self.
    for (int a = 0; a < 16; a++) begin
      av = 4'(a);
      d  = 8'($urandom);
      if (a == 0) d = 8'h35;
      if (a == 1) d = 8'h01;
      if (a == 6) d = 8'h80;
      if (d[7:4] == 4'hF && d[3:0] == av) d[3:0] = av + 4'd1;
      load_word(av, d);
    end

    // Single step of mem[0]. A write attempt during FETCH must be refused.
    ip = 4'h0;
    step_req = 1'b1;
    @(negedge clk);
    step_req   = 1'b0;
    prog_valid = 1'b1; prog_addr = 4'h2; prog_data = 8'hFF;
    check("step_fetch_novalid", issue_valid, 1'b0);
    check("fetch_prog_ready", prog_ready, 1'b0);
    @(negedge clk);
    prog_valid = 1'b0;
    check("step0_op_const", op, 4'h3);
    check("step0_imm_const", imm, 4'h5);
    expect_instr("step0", 4'h0);
    handshake_to_idle("step0");

    // Stall: ready low for 5 cycles. ip wanders and a write is attempted.
    do_step("stall", 4'h1);
    for (int k = 0; k < 5; k++) begin
      ip = 4'($urandom);
      prog_valid = 1'b1; prog_addr = 4'h2; prog_data = 8'hFF;
      @(negedge clk);
      check("stall_prog_ready", prog_ready, 1'b0);
      expect_instr("stall", 4'h1);
    end
    prog_valid = 1'b0;
    ip = 4'h1;
    handshake_to_idle("stall");

    // Free run: ip model advances on each handshake and wraps 15->0.
    // Consecutive issues must be exactly 2 cycles apart.
    ipm = 4'h0; ip = ipm; run = 1'b1; issue_ready = 1'b1;
    for (int h = 0; h < 20; h++) begin
      @(negedge clk);
      cyc = 1;
      while (!issue_valid && cyc < 6) begin
        @(negedge clk);
        cyc++;
      end
      check("run_spacing", 32'(cyc), 32'd2);
      expect_instr("run", ipm);
      if (h == 19) run = 1'b0;
      @(posedge clk);
      #1;
      ipm = ipm + 4'd1;
      ip  = ipm;
    end
    issue_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("run_stop_novalid", issue_valid, 1'b0);
    end
    check("run_stop_idle", prog_ready, 1'b1);

    // Randomized ready pattern during free run.
    hs = 0;
    ipm = 4'($urandom); ip = ipm; run = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      rdy = 1'($urandom_range(0, 1));
      issue_ready = rdy;
      if (issue_valid) begin
        expect_instr("rand", ipm);
        if (rdy) begin
          hs++;
          @(posedge clk);
          #1;
          ipm = ipm + 4'd1;
          ip  = ipm;
        end
      end
    end
    @(negedge clk);
    run = 1'b0;
    issue_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (issue_valid) begin
        expect_instr("rand_drain", ipm);
        @(posedge clk);
        #1;
        ipm = ipm + 4'd1;
        ip  = ipm;
      end
      @(negedge clk);
    end
    issue_ready = 1'b0;
    check("rand_hs_seen", 32'(hs > 0), 32'd1);
    check("rand_end_novalid", issue_valid, 1'b0);
    check("rand_end_idle", prog_ready, 1'b1);

    // Load and step in the same IDLE cycle: the write wins and no fetch starts.
    ip = 4'h5;
    step_req = 1'b1;
    load_word(4'h5, 8'h9A);
    step_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("load_prio_novalid", issue_valid, 1'b0);
      check("load_prio_idle", prog_ready, 1'b1);
      @(negedge clk);
    end

    // Illegal opcode is still issued. Reset in ISSUE then drops it.
    do_step("illegal", 4'h6);
    check("illegal_legal_const", op_legal, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_issue_valid", issue_valid, 1'b0);
    check("rst_issue_op", op, 4'h0);
    @(negedge clk);
    check("rst_issue_idle", prog_ready, 1'b1);
    check("rst_issue_valid2", issue_valid, 1'b0);

    // Memory survives reset; the load-priority write and the refused writes show up.
    do_step("readback5", 4'h5);
    handshake_to_idle("readback5");
    do_step("readback2", 4'h2);
    handshake_to_idle("readback2");
    do_step("readback6", 4'h6);
    handshake_to_idle("readback6");

`ifdef TD4_HALT_DETECT_EN
    // JMP-to-self halts after its handshake. Only dropping run releases it.
    load_word(4'h3, 8'hF3);
    ipm = 4'h3; ip = ipm; run = 1'b1; issue_ready = 1'b1;
    cyc = 0;
    while (!issue_valid && cyc < 6) begin
      @(negedge clk);
      cyc++;
    end
    expect_instr("halt", 4'h3);
    @(negedge clk);
    check("halt_halted", halted, 1'b1);
    check("halt_novalid", issue_valid, 1'b0);
    check("halt_prog_ready", prog_ready, 1'b0);
    step_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      step_req = 1'b0;
      check("halt_hold_halted", halted, 1'b1);
      check("halt_hold_novalid", issue_valid, 1'b0);
    end
    run = 1'b0;
    issue_ready = 1'b0;
    @(negedge clk);
    check("halt_release", halted, 1'b0);
    check("halt_release_idle", prog_ready, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
